// File: rtl/lut_reg_lut_arbiter.sv
// Round-robin front end sharing a three-register AND-reduction pipeline
// among NUM_REQ requesters. Each issued operand is reduced in two LUT-sized
// steps (low SPLIT bits, then the remaining high bits) and the result returns
// on a single in-order response bus tagged with the requester ID.
module lut_reg_lut_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int WIDTH   = 8,
    parameter int SPLIT   = 6
) (
    input  logic                     clock0,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     drain,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     rsp_data,
    output logic [1:0]               inflight,
    output logic                     idle
);

    // First LUT level: reduce the low SPLIT operand bits.
    function automatic logic and_low(input logic [WIDTH-1:0] d);
        return &d[SPLIT-1:0];
    endfunction

    // Second LUT level: merge the partial result with the high bits.
    function automatic logic and_merge(input logic lo, input logic [WIDTH-SPLIT-1:0] hi);
        return lo & (&hi);
    endfunction

    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        grant_idx;
    logic [ID_W-1:0]        scan_idx;
    logic                   grant_hit;
    logic [WIDTH-1:0]       grant_data;

    logic                   vld_p1;
    logic [WIDTH-1:0]       data_p1;
    logic [ID_W-1:0]        id_p1;

    logic                   vld_p2;
    logic                   and_lo_p2;
    logic [WIDTH-SPLIT-1:0] hi_p2;
    logic [ID_W-1:0]        id_p2;

    // Scan requesters starting at rr_ptr; the first valid one wins unless draining.
    always_comb begin
        req_ready = '0;
        grant_idx = '0;
        grant_hit = 1'b0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = rr_ptr + ID_W'(k);
            if (!grant_hit && !drain && req_valid[scan_idx]) begin
                grant_hit = 1'b1;
                grant_idx = scan_idx;
            end
        end
        if (grant_hit) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign grant_data = req_data[grant_idx*WIDTH +: WIDTH];

    // Pointer moves just past the granted requester; holds when nothing issues.
    always_ff @(posedge clock0 or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (grant_hit) begin
            rr_ptr <= grant_idx + ID_W'(1);
        end
    end

    // ---- stage 1: capture the granted operand and its requester ID ----
    always_ff @(posedge clock0 or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            id_p1   <= '0;
        end else begin
            vld_p1  <= grant_hit;
            data_p1 <= grant_data;
            id_p1   <= grant_idx;
        end
    end

    // ---- stage 2: wide reduction of the low bits, carry the high bits ----
    always_ff @(posedge clock0 or negedge reset_n) begin
        if (!reset_n) begin
            vld_p2    <= 1'b0;
            and_lo_p2 <= 1'b0;
            hi_p2     <= '0;
            id_p2     <= '0;
        end else begin
            vld_p2    <= vld_p1;
            and_lo_p2 <= and_low(data_p1);
            hi_p2     <= data_p1[WIDTH-1:SPLIT];
            id_p2     <= id_p1;
        end
    end

    // ---- stage 3: narrow merge into the registered response ----
    always_ff @(posedge clock0 or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= 1'b0;
        end else begin
            rsp_valid <= vld_p2;
            rsp_id    <= id_p2;
            rsp_data  <= and_merge(and_lo_p2, hi_p2);
        end
    end

    assign inflight = {1'b0, vld_p1} + {1'b0, vld_p2} + {1'b0, rsp_valid};
    assign idle     = drain & ~vld_p1 & ~vld_p2 & ~rsp_valid;

endmodule

// File: tb/tb_lut_reg_lut_arbiter.sv
// Bench for lut_reg_lut_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-style behavioural model.
module tb_lut_reg_lut_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic           clk;
    logic           reset_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           drain;
    logic           rsp_valid;
    logic [IW-1:0]  rsp_id;
    logic           rsp_data;
    logic [1:0]     inflight;
    logic           idle;

    int checks = 0;
    int errors = 0;

    // model state: round-robin pointer and a three-deep delay line of issues
    int rr_m;
    bit pv[3];
    int pid[3];
    bit pdat[3];

    lut_reg_lut_arbiter #(.NUM_REQ(N), .ID_W(IW), .WIDTH(W), .SPLIT(6)) dut (
        .clock0(clk),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .drain(drain),
        .rsp_valid(rsp_valid),
        .rsp_id(rsp_id),
        .rsp_data(rsp_data),
        .inflight(inflight),
        .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        rr_m = 0;
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0;
            pid[i] = 0;
            pdat[i] = 1'b0;
        end
    endtask

    // Winner is the first valid requester at or after the pointer, modulo N.
    function automatic int exp_grant();
        if (drain) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(rr_m + k) % N]) return (rr_m + k) % N;
        end
        return -1;
    endfunction

    // Compare every output against the model a little after inputs settle.
    task automatic settle_check();
        int g;
        int cnt;
        #1;
        g = exp_grant();
        chk("req_ready", int'(req_ready), (g >= 0) ? (1 << g) : 0);
        chk("rsp_valid", int'(rsp_valid), int'(pv[2]));
        if (pv[2]) begin
            chk("rsp_id", int'(rsp_id), pid[2]);
            chk("rsp_data", int'(rsp_data), int'(pdat[2]));
        end
        cnt = int'(pv[0]) + int'(pv[1]) + int'(pv[2]);
        chk("inflight", int'(inflight), cnt);
        chk("idle", int'(idle), (drain && cnt == 0) ? 1 : 0);
    endtask

    // Advance one clock; the model follows the same edge.
    task automatic clk_adv();
        int g;
        logic [W-1:0] d;
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else begin
            g = exp_grant();
            pv[2] = pv[1]; pid[2] = pid[1]; pdat[2] = pdat[1];
            pv[1] = pv[0]; pid[1] = pid[0]; pdat[1] = pdat[0];
            pv[0] = (g >= 0);
            pid[0] = (g >= 0) ? g : 0;
            if (g >= 0) begin
                d = req_data[g*W +: W];
                pdat[0] = (d == 8'hFF);
                rr_m = (g + 1) % N;
            end else begin
                pdat[0] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic step();
        settle_check();
        clk_adv();
    endtask

    task automatic single(input logic [W-1:0] d, input int exp_bit);
        req_valid = 4'b0100;
        req_data = '0;
        req_data[2*W +: W] = d;
        settle_check();
        chk("single_grant", int'(req_ready), 4);
        clk_adv();
        req_valid = '0;
        req_data = '0;
        step();
        step();
        settle_check();
        chk("single_rsp_valid", int'(rsp_valid), 1);
        chk("single_rsp_id", int'(rsp_id), 2);
        chk("single_rsp_data", int'(rsp_data), exp_bit);
        clk_adv();
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 2))
            0: return 8'hFF;
            1: return 8'hFF ^ (8'h01 << $urandom_range(0, 7));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        reset_n = 1'b0;
        drain = 1'b0;
        req_valid = '0;
        req_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // quiet after reset
        for (int i = 0; i < 5; i++) begin
            settle_check();
            chk("rst_ready", int'(req_ready), 0);
            chk("rst_rsp_valid", int'(rsp_valid), 0);
            chk("rst_inflight", int'(inflight), 0);
            chk("rst_idle", int'(idle), 0);
            clk_adv();
        end

        // single requests exercising each reduction level
        single(8'hFF, 1);
        single(8'hDF, 0);
        single(8'h7F, 0);

        // reset so the round-robin sequence starts at requester 0
        reset_n = 1'b0;
        clk_adv();
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            req_valid = (i < 8) ? 4'b1111 : 4'b0000;
            for (int r = 0; r < N; r++) req_data[r*W +: W] = rand_operand();
            settle_check();
            if (i < 8) chk("rr_grant", int'(req_ready), 1 << (i % 4));
            if (i >= 3 && i < 8) chk("rr_inflight", int'(inflight), 3);
            if (i >= 3) begin
                chk("rr_rsp_valid", int'(rsp_valid), 1);
                chk("rr_rsp_id", int'(rsp_id), (i - 3) % 4);
            end
            clk_adv();
        end
        req_data = '0;

        // drain behaviour
        req_valid = 4'b0010;
        settle_check();
        chk("drain_issue", int'(req_ready), 2);
        clk_adv();
        drain = 1'b1;
        req_valid = 4'b1010;
        settle_check();
        chk("drain_gate", int'(req_ready), 0);
        clk_adv();
        step();
        step();
        settle_check();
        chk("drain_idle", int'(idle), 1);
        chk("drain_inflight", int'(inflight), 0);
        clk_adv();
        drain = 1'b0;
        req_valid = 4'b1000;
        settle_check();
        chk("undrain_grant", int'(req_ready), 8);
        clk_adv();

        // asynchronous reset with a full pipe
        req_valid = 4'b1111;
        req_data = {N{8'hFF}};
        repeat (4) step();
        settle_check();
        chk("pre_reset_inflight", int'(inflight), 3);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("ares_rsp_valid", int'(rsp_valid), 0);
        chk("ares_inflight", int'(inflight), 0);
        chk("ares_rsp_id", int'(rsp_id), 0);
        chk("ares_rsp_data", int'(rsp_data), 0);
        chk("ares_idle", int'(idle), 0);
        clk_adv();
        reset_n = 1'b1;
        settle_check();
        chk("post_reset_grant", int'(req_ready), 1);
        clk_adv();
        req_valid = '0;
        repeat (4) step();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            req_valid = N'($urandom);
            drain = ($urandom_range(0, 9) == 0);
            for (int r = 0; r < N; r++) req_data[r*W +: W] = rand_operand();
            step();
        end
        drain = 1'b1;
        req_valid = '0;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
